// File: rtl/mult_pkg.sv
// Shared types for the sequential fixed-point multiplier: FSM state encoding
// and the counter-width helper.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Bits needed to hold the values 0..n-1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Combinational round/saturate of the (2N-2)-bit magnitude product into N-bit sign-magnitude.
// Zero latency; no flow control, the caller registers the outputs.
module fxp_round_sat #(
  parameter int N        = 32,
  parameter int FRACBITS = 20,
  parameter int ROUND    = 1,
  parameter int SATURATE = 1
) (
  input  logic [2*N-3:0] prod,
  input  logic           sign,
  output logic [N-1:0]   result,
  output logic           ovf
);

  localparam int M = N - 1;

  generate
    if (FRACBITS >= N - 1) begin : g_bad_fracbits
      $error("fxp_round_sat: FRACBITS must be less than N-1");
    end
  endgenerate

  logic [M-1:0] base;
  logic [M-1:0] mag;
  logic [N-1:0] rounded;
  logic         inc;
  logic         hi_ovf;
  logic         unused_prod;

  assign base = prod[N+FRACBITS-2:FRACBITS];

  generate
    if (ROUND != 0 && FRACBITS > 0) begin : g_round
      assign inc = prod[FRACBITS-1];
    end else begin : g_trunc
      assign inc = 1'b0;
    end
  endgenerate

  // Bits below the rounding position only matter for exactness, never for the result.
  assign unused_prod = ^prod;

  assign hi_ovf  = |prod[2*N-3:N+FRACBITS-1];
  assign rounded = {1'b0, base} + N'(inc);
  assign ovf     = hi_ovf | rounded[N-1];
  assign mag     = (ovf && SATURATE != 0) ? {M{1'b1}} : rounded[M-1:0];
  assign result  = {sign && (mag != '0), mag};

endmodule

// File: rtl/seq_fxp_multiplier.sv
// Sequential radix-2 sign-magnitude fixed-point multiplier; out_valid N+1 edges after accept.
// One operation in flight: in_ready only in IDLE, result held in DONE until out_ready.
module seq_fxp_multiplier
  import mult_pkg::*;
#(
  parameter int N        = 32,
  parameter int FRACBITS = 20,
  parameter int ROUND    = 1,
  parameter int SATURATE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         ovf,
  output logic         ovf_sticky,
  input  logic         clr_sticky
);

  localparam int M  = N - 1;
  localparam int PW = 2 * N - 2;
  localparam int CW = clog2(N);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] acc;
  logic [PW-1:0] mcand;
  logic [M-1:0]  mplier;
  logic          sgn;
  logic [N-1:0]  fin_result;
  logic          fin_ovf;

  fxp_round_sat #(
    .N        (N),
    .FRACBITS (FRACBITS),
    .ROUND    (ROUND),
    .SATURATE (SATURATE)
  ) u_round_sat (
    .prod   (acc),
    .sign   (sgn),
    .result (fin_result),
    .ovf    (fin_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      result     <= '0;
      ovf        <= 1'b0;
      ovf_sticky <= 1'b0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      cnt        <= '0;
      sgn        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            sgn      <= a[N-1] ^ b[N-1];
            mcand    <= PW'(a[M-1:0]);
            mplier   <= b[M-1:0];
            acc      <= '0;
            cnt      <= CW'(M);
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          // The counter reaching zero marks N-1 completed steps.
          if (cnt == '0) begin
            state <= FIN;
          end else begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
          end
        end
        FIN: begin
          result    <= fin_result;
          ovf       <= fin_ovf;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // A delivered overflow outranks a simultaneous clear.
      if (state == DONE && out_ready && ovf) ovf_sticky <= 1'b1;
      else if (clr_sticky)                   ovf_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_fxp_multiplier.sv
// Directed bench: default instance (round, saturate) and a truncate/wrap instance
// share stimulus and run in lockstep.
module tb_seq_fxp_multiplier;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic         clr_sticky;
  logic [N-1:0] a;
  logic [N-1:0] b;

  logic         in_ready,   out_valid,   ovf,   ovf_sticky;
  logic [N-1:0] result;
  logic         in_ready_t, out_valid_t, ovf_t, ovf_sticky_t;
  logic [N-1:0] result_t;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_fxp_multiplier #(.N(N), .FRACBITS(20), .ROUND(1), .SATURATE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .ovf(ovf), .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky)
  );

  seq_fxp_multiplier #(.N(N), .FRACBITS(20), .ROUND(0), .SATURATE(0)) dut_t (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_t),
    .a(a), .b(b), .out_valid(out_valid_t), .out_ready(out_ready),
    .result(result_t), .ovf(ovf_t), .ovf_sticky(ovf_sticky_t), .clr_sticky(clr_sticky)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [31:0] va, input logic [31:0] vb);
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
  endtask

  task automatic wait_done(input string tag);
    int lat;
    lat = 0;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, 33);
    chk({tag, "_vld_t"}, out_valid_t, 1'b1);
  endtask

  task automatic handshake(input logic clr);
    out_ready  = 1'b1;
    clr_sticky = clr;
    tick();
    out_ready  = 1'b0;
    clr_sticky = 1'b0;
  endtask

  task automatic op_check(input string tag, input logic [31:0] va, input logic [31:0] vb,
                          input logic [31:0] er, input logic eo,
                          input logic [31:0] er_t, input logic eo_t);
    start_op(va, vb);
    wait_done(tag);
    chk({tag, "_res"},   result,   er);
    chk({tag, "_ovf"},   ovf,      eo);
    chk({tag, "_res_t"}, result_t, er_t);
    chk({tag, "_ovf_t"}, ovf_t,    eo_t);
  endtask

  initial begin
    int seen;
    logic [31:0] held;

    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    clr_sticky = 1'b0;
    a          = '0;
    b          = '0;
    tick();
    tick();
    chk("rst_in_ready",  in_ready,   1'b1);
    chk("rst_out_valid", out_valid,  1'b0);
    chk("rst_result",    result,     32'h0);
    chk("rst_ovf",       ovf,        1'b0);
    chk("rst_sticky",    ovf_sticky, 1'b0);
    rst = 1'b0;
    tick();

    // 1.5 * -2.0 = -3.0
    op_check("mul_neg", 32'h0018_0000, 32'h8020_0000, 32'h8030_0000, 1'b0, 32'h8030_0000, 1'b0);
    handshake(1'b0);
    chk("mul_neg_sticky", ovf_sticky, 1'b0);
    chk("mul_neg_idle",   in_ready,   1'b1);

    // 1024 * 4 = 4096 overflows; wrap keeps low 31 bits of 2^32 -> zero
    op_check("ovf", 32'h4000_0000, 32'h0040_0000, 32'h7FFF_FFFF, 1'b1, 32'h0000_0000, 1'b1);
    chk("ovf_sticky_pre", ovf_sticky, 1'b0);
    handshake(1'b0);
    chk("ovf_sticky_post",   ovf_sticky,   1'b1);
    chk("ovf_sticky_post_t", ovf_sticky_t, 1'b1);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    chk("sticky_clr", ovf_sticky, 1'b0);

    // Set and clear on the same edge: set wins
    op_check("ovf2", 32'h4000_0000, 32'h0040_0000, 32'h7FFF_FFFF, 1'b1, 32'h0000_0000, 1'b1);
    handshake(1'b1);
    chk("sticky_set_wins", ovf_sticky, 1'b1);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    chk("sticky_clr2", ovf_sticky, 1'b0);

    // 2^-20 * 0.5: rounds up to 1 lsb, truncates to zero
    op_check("round", 32'h0000_0001, 32'h0008_0000, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b0);
    handshake(1'b0);

    // Negative underflow to zero must not keep the sign
    op_check("negzero", 32'h8000_0001, 32'h0000_0001, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0);
    handshake(1'b0);

    // -1.0 * -1.0 = 1.0, then hold in DONE for 5 cycles
    op_check("hold", 32'h8010_0000, 32'h8010_0000, 32'h0010_0000, 1'b0, 32'h0010_0000, 1'b0);
    held = result;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_res",      result,    held);
      chk("hold_ovf",      ovf,       1'b0);
      chk("hold_vld",      out_valid, 1'b1);
      chk("hold_in_ready", in_ready,  1'b0);
    end
    handshake(1'b0);
    chk("hold_idle_in_ready",  in_ready,  1'b1);
    chk("hold_idle_out_valid", out_valid, 1'b0);

    // Reset pulse in the middle of BUSY abandons the operation
    start_op(32'h0018_0000, 32'h0020_0000);
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_in_ready",  in_ready,  1'b1);
    chk("midrst_out_valid", out_valid, 1'b0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid || out_valid_t) seen++;
    end
    chk("midrst_no_result", seen, 0);

    // 2.5 * -3.0 = -7.5
    op_check("after_rst", 32'h0028_0000, 32'h8030_0000, 32'h8078_0000, 1'b0, 32'h8078_0000, 1'b0);
    handshake(1'b0);
    chk("after_rst_idle", in_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_fxp_multiplier.md
SEQ_FXP_MULTIPLIER -- requirements
Module: seq_fxp_multiplier

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning total word width in bits, sign included.
REQ-002 The block SHALL have parameter FRACBITS, default 20, meaning the number of fractional magnitude bits.
REQ-003 The block SHALL have parameter ROUND, default 1: 1 = round-half-up on magnitude, 0 = truncate.
REQ-004 The block SHALL have parameter SATURATE, default 1: 1 = clamp on overflow, 0 = wrap (drop high bits).
REQ-005 Port clk, input, 1 bit: the only clock; all state SHALL update on its rising edge.
REQ-006 Port rst, input, 1 bit: reset SHALL be synchronous and active-high.
REQ-007 Port in_valid, input, 1: operands a and b are valid.
REQ-008 Port in_ready, output, 1: the block accepts operands.
REQ-009 Ports a and b, input, N bits each: sign-magnitude fixed point; bit N-1 is the sign and bits N-2:0 are the magnitude with FRACBITS fraction bits.
REQ-010 Port out_valid, output, 1: result and ovf are valid.
REQ-011 Port out_ready, input, 1: the consumer accepts the result.
REQ-012 Port result, output, N bits: product in the same format as a and b.
REQ-013 Port ovf, output, 1: the current result overflowed.
REQ-014 Port ovf_sticky, output, 1: OR of ovf over all results delivered since reset or the last clear.
REQ-015 Port clr_sticky, input, 1: clears ovf_sticky.

Function
REQ-016 FSM states SHALL be IDLE, BUSY, FIN and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-017 On in_valid && in_ready in IDLE, the block SHALL latch the sign XOR and both magnitudes, clear the accumulator, load the iteration counter with N-1, and go to BUSY.
REQ-018 BUSY SHALL do one radix-2 shift-add step per cycle over the bits of b's magnitude, building the exact (2N-2)-bit magnitude product, and SHALL go to FIN after exactly N-1 steps.
REQ-019 FIN SHALL take one cycle, SHALL register result and ovf, and SHALL then go to DONE; out_valid SHALL first be high N+1 edges after the accepting edge (33 for N=32).
REQ-020 Rounding: mag = P[N+FRACBITS-2:FRACBITS], plus P[FRACBITS-1] when ROUND=1.
REQ-021 Overflow (ovf=1) SHALL be set when any of P[2N-3:N+FRACBITS-1] is set or when the rounding increment carries out of N-1 bits.
REQ-022 On overflow, the magnitude SHALL be all-ones (2^(N-1)-1) when SATURATE=1, or the low N-1 bits of the rounded magnitude when SATURATE=0.
REQ-023 The result sign SHALL be a[N-1]^b[N-1], except that it SHALL be forced to 0 when the final magnitude is 0 (no negative zero).
REQ-024 In DONE, result and ovf SHALL hold stable while out_ready=0; on out_ready=1 the block SHALL go to IDLE, with in_ready rising the next cycle (no same-cycle re-accept).
REQ-025 ovf_sticky SHALL set on the DONE handshake when ovf=1; clr_sticky SHALL clear it, and when both occur in the same cycle, set wins.
REQ-026 Inputs a and b SHALL be ignored outside the accepting cycle, and operand changes during BUSY SHALL have no effect.

Reset
REQ-027 While rst=1 at an edge, the block SHALL go to IDLE, and in_ready=1 SHALL appear after the first edge with rst=1.
REQ-028 While rst=1 at an edge, out_valid, ovf, ovf_sticky and result (all zeros) SHALL clear, as SHALL the accumulator and the counter.
REQ-029 Reset during BUSY, FIN or DONE SHALL abandon the operation, and no result SHALL be delivered.

Structure
REQ-030 A shared package mult_pkg SHALL hold the state enum (IDLE, BUSY, FIN, DONE) and a counter-width function clog2(N).
REQ-031 One sub-module, fxp_round_sat, SHALL implement REQ-020 to REQ-023 combinationally for the FIN stage.
REQ-032 Elaboration SHALL fail when FRACBITS >= N-1.

Verification
REQ-033 With N=32, FRACBITS=20, a=0x00180000 (1.5) and b=0x80200000 (-2.0), the bench SHALL see result=0x80300000, ovf=0, and out_valid on the 33rd edge after acceptance.
REQ-034 With a=0x40000000 (1024.0) and b=0x00400000 (4.0), the bench SHALL see result=0x7FFFFFFF and ovf=1 when SATURATE=1, and ovf_sticky=1 after the handshake.
REQ-035 With a=0x00000001 and b=0x00080000 (0.5), the bench SHALL see result=0x00000001 when ROUND=1 and 0x00000000 when ROUND=0.
REQ-036 With a=0x80000001 and b=0x00000001, the bench SHALL see result=0x00000000 with sign cleared and ovf=0.
REQ-037 With out_ready held 0 for 5 cycles in DONE, the bench SHALL see result and ovf stable and in_ready=0, and in IDLE one cycle after out_ready=1.
REQ-038 With rst pulsed for 1 cycle mid-BUSY, the bench SHALL see no out_valid, in_ready=1 after that edge, and the next operation correct.
